// File: rtl/tt_sweep.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_sweep : drives all 64 vectors of a 6-input function, captures its truth
//            table, counts ones and compares against an expected table. Rev 1.0
// ---------------------------------------------------------------------------
module tt_sweep #(
   parameter int SETTLE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        x0,
   output logic        x1,
   output logic        x2,
   output logic        x3,
   output logic        x4,
   output logic        x5,
   input  logic        y0,
   input  logic [63:0] exp_tt,
   output logic        busy,
   output logic        done,
   output logic [63:0] tt,
   output logic [6:0]  ones,
   output logic        match
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   state_t      state;
   state_t      state_next;
   logic [5:0]  idx;
   logic [3:0]  wait_cnt;
   logic        sample;
   logic        last;
   logic        launch;
   logic [63:0] tt_next;

   assign sample = (state == RUN) && (wait_cnt == SETTLE_CNT);
   assign last   = sample && (idx == 6'd63);
   assign launch = start && (state != RUN);

   always_comb begin
      tt_next      = tt;
      tt_next[idx] = y0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // idx returns to 0 on completion so it can drive the x outputs directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx      <= 6'd0;
         wait_cnt <= 4'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tt       <= 64'd0;
         ones     <= 7'd0;
         match    <= 1'b0;
      end else if (launch) begin
         idx      <= 6'd0;
         wait_cnt <= 4'd0;
         busy     <= 1'b1;
         done     <= 1'b0;
         tt       <= 64'd0;
         ones     <= 7'd0;
         match    <= 1'b0;
      end else if (state == RUN) begin
         if (sample) begin
            tt       <= tt_next;
            ones     <= ones + {6'd0, y0};
            wait_cnt <= 4'd0;
            if (last) begin
               idx   <= 6'd0;
               busy  <= 1'b0;
               done  <= 1'b1;
               match <= (tt_next == exp_tt);
            end else begin
               idx <= idx + 6'd1;
            end
         end else begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   assign {x5, x4, x3, x2, x1, x0} = idx;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep.sv
`default_nettype none
// tb_tt_sweep : scoreboard bench driving a SETTLE=0 and a SETTLE=2 tt_sweep
//               with hand-computed truth tables.
module tb_tt_sweep;

   typedef struct {
      logic [63:0] tt;
      logic [6:0]  ones;
      logic        match;
      int          cycles;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start;
   int          mode [2];
   logic [63:0] expv [2];

   wire  [5:0]  x    [2];
   wire  [1:0]  y0;
   wire  [1:0]  busy;
   wire  [1:0]  done;
   wire  [1:0]  match;
   wire  [63:0] tt   [2];
   wire  [6:0]  ones [2];

   exp_t q_a [$];
   exp_t q_b [$];
   int   passed = 0;
   int   total  = 0;
   int   bcnt  [2];
   int   xerr  [2];
   logic pdone [2];

   always #5 clk = ~clk;

   function automatic logic fut(input int m, input logic [5:0] xv);
      case (m)
         0:       fut = xv[0] & xv[1];
         1:       fut = 1'b1;
         2:       fut = xv[5];
         3:       fut = xv[0];
         default: fut = 1'b0;
      endcase
   endfunction

   assign y0[0] = fut(mode[0], x[0]);
   assign y0[1] = fut(mode[1], x[1]);

   tt_sweep #(.SETTLE(0)) u_s0 (
      .clk(clk), .rst(rst), .start(start[0]),
      .x0(x[0][0]), .x1(x[0][1]), .x2(x[0][2]), .x3(x[0][3]), .x4(x[0][4]), .x5(x[0][5]),
      .y0(y0[0]), .exp_tt(expv[0]), .busy(busy[0]), .done(done[0]),
      .tt(tt[0]), .ones(ones[0]), .match(match[0])
   );

   tt_sweep #(.SETTLE(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start[1]),
      .x0(x[1][0]), .x1(x[1][1]), .x2(x[1][2]), .x3(x[1][3]), .x4(x[1][4]), .x5(x[1][5]),
      .y0(y0[1]), .exp_tt(expv[1]), .busy(busy[1]), .done(done[1]),
      .tt(tt[1]), .ones(ones[1]), .match(match[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Monitor: tracks busy length and the x sequence, pops the scoreboard when done rises.
   always @(negedge clk) begin : mon
      exp_t e;
      bit   got;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            bcnt[k]  = 0;
            xerr[k]  = 0;
            pdone[k] = 1'b0;
         end else begin
            if (busy[k]) begin
               if (x[k] !== 6'(bcnt[k] / ((k == 0) ? 1 : 3))) xerr[k]++;
               bcnt[k]++;
            end
            if (done[k] && !pdone[k]) begin
               got = 1'b0;
               if (k == 0 && q_a.size() != 0) begin e = q_a.pop_front(); got = 1'b1; end
               if (k == 1 && q_b.size() != 0) begin e = q_b.pop_front(); got = 1'b1; end
               check($sformatf("inst%0d expected result queued", k), 64'(got), 64'd1);
               if (got) begin
                  check($sformatf("inst%0d tt", k), tt[k], e.tt);
                  check($sformatf("inst%0d ones", k), 64'(ones[k]), 64'(e.ones));
                  check($sformatf("inst%0d match", k), 64'(match[k]), 64'(e.match));
                  check($sformatf("inst%0d busy cycles", k), 64'(bcnt[k]), 64'(e.cycles));
                  check($sformatf("inst%0d x sequence errors", k), 64'(xerr[k]), 64'd0);
               end
               bcnt[k] = 0;
               xerr[k] = 0;
            end
            pdone[k] = done[k];
         end
      end
   end

   task automatic check_zero(input int k, input string tag);
      check($sformatf("%s inst%0d x", tag, k), 64'(x[k]), 64'd0);
      check($sformatf("%s inst%0d busy", tag, k), 64'(busy[k]), 64'd0);
      check($sformatf("%s inst%0d done", tag, k), 64'(done[k]), 64'd0);
      check($sformatf("%s inst%0d tt", tag, k), tt[k], 64'd0);
      check($sformatf("%s inst%0d ones", tag, k), 64'(ones[k]), 64'd0);
      check($sformatf("%s inst%0d match", tag, k), 64'(match[k]), 64'd0);
   endtask

   task automatic pulse_start(input int k);
      @(posedge clk); #1 start[k] = 1'b1;
      @(posedge clk); #1 start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (!done[k] && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("inst%0d done within bound", k), 64'(done[k]), 64'd1);
   endtask

   // opt: 0 plain, 1 re-pulse start at RUN cycle 10, 2 check outputs cleared after start
   task automatic run_sweep(input int k, input int m, input logic [63:0] e,
                            input logic [63:0] ett, input int n1, input logic mt, input int opt);
      exp_t r;
      mode[k]  = m;
      expv[k]  = e;
      r.tt     = ett;
      r.ones   = 7'(n1);
      r.match  = mt;
      r.cycles = 64 * ((k == 0) ? 1 : 3);
      if (k == 0) q_a.push_back(r);
      else        q_b.push_back(r);
      pulse_start(k);
      if (opt == 2) begin
         check("restart done dropped", 64'(done[k]), 64'd0);
         check("restart busy", 64'(busy[k]), 64'd1);
         check("restart tt cleared", tt[k], 64'd0);
         check("restart ones cleared", 64'(ones[k]), 64'd0);
      end
      if (opt == 1) begin
         repeat (9) @(posedge clk);
         #1 start[k] = 1'b1;
         @(posedge clk); #1 start[k] = 1'b0;
      end
      wait_done(k);
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      start   = 2'b00;
      mode[0] = 0;
      mode[1] = 0;
      expv[0] = 64'd0;
      expv[1] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      check_zero(0, "reset");
      check_zero(1, "reset");
      @(negedge clk) rst = 1'b0;

      run_sweep(0, 0, 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888, 16, 1'b1, 0);
      run_sweep(0, 1, '1, '1, 64, 1'b1, 0);
      run_sweep(0, 1, 64'hFFFF_FFFF_FFFF_FFDF, '1, 64, 1'b0, 0);
      run_sweep(0, 0, 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888, 16, 1'b1, 1);
      run_sweep(0, 3, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 32, 1'b1, 2);

      // Abort a sweep at idx 30 with reset, then run a full fresh sweep.
      mode[0] = 0;
      pulse_start(0);
      n = 0;
      while (x[0] != 6'd30 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("reached idx 30", 64'(x[0]), 64'd30);
      rst = 1'b1;
      #1;
      check_zero(0, "mid-sweep reset");
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      run_sweep(0, 0, 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888, 16, 1'b1, 0);

      run_sweep(1, 2, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 32, 1'b1, 0);

      @(negedge clk);
      #1;
      check("inst0 scoreboard drained", 64'(q_a.size()), 64'd0);
      check("inst1 scoreboard drained", 64'(q_b.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
